dmi_arbiter: RTL and testbench
==============================

# dmi_arbiter

Shares a single DMI request/response channel between `NumReq` requesters on the debug-module clock domain, e.g. the JTAG DTM's CDC output and an on-chip debug bridge, with one transaction outstanding at a time. Requests are granted round-robin and latched. The downstream DMI handshake is driven from the latched copy. The single response is routed back to the granted requester only. The block sits between the requester-side DMI ports and the debug module's `dmi_req`/`dmi_resp` ports.

## Interface
Parameters:
- `NumReq`, default 2: number of requesters. Legal range is 1..16.

Ports:
- `clk_i`, in, 1 bit: DMI clock. This is the single clock of the block.
- `rst_ni`, in, 1 bit: asynchronous, active-low reset.
- `req_i`, in, `[NumReq-1:0]` of `dm::dmi_req_t`: per-requester request (addr, op, data).
- `req_valid_i`, in, `[NumReq-1:0]`: per-requester request valid.
- `req_ready_o`, out, `[NumReq-1:0]`: per-requester accept. One-hot or zero.
- `resp_o`, out, `dm::dmi_resp_t`: response bus, shared by all requesters.
- `resp_valid_o`, out, `[NumReq-1:0]`: response valid. Asserted only on the granted index.
- `resp_ready_i`, in, `[NumReq-1:0]`: per-requester response ready.
- `dmi_req_o`, out, `dm::dmi_req_t`: downstream request. Held stable while valid.
- `dmi_req_valid_o`, out, 1 bit: downstream request valid.
- `dmi_req_ready_i`, in, 1 bit: downstream request ready.
- `dmi_resp_i`, in, `dm::dmi_resp_t`: downstream response.
- `dmi_resp_valid_i`, in, 1 bit: downstream response valid.
- `dmi_resp_ready_o`, out, 1 bit: downstream response ready.

## Operation
State machine states are Idle, Req and Resp. State registers:
- `grant_q`: `max(1,$clog2(NumReq))` bits.
- `rr_q`: priority pointer, same width as `grant_q`.
- `req_q`: latched `dm::dmi_req_t`.

Idle:
- Select the first `i` with `req_valid_i[i]`, scanning `rr_q`, `rr_q+1`, … up to `NumReq-1`, then wrapping to 0 and continuing to `rr_q-1`.
- On a hit: assert `req_ready_o[i]`, latch `req_q <= req_i[i]` and `grant_q <= i`, and go to Req.
- With no valid request, stay in Idle. All outputs are deasserted.

Req:
- `dmi_req_valid_o = 1` and `dmi_req_o = req_q`.
- On `dmi_req_ready_i`, go to Resp.
- `req_ready_o` is all zero.

Resp:
- `resp_o = dmi_resp_i`.
- `resp_valid_o[grant_q] = dmi_resp_valid_i`; all other bits are 0.
- `dmi_resp_ready_o = resp_ready_i[grant_q]`.
- On `dmi_resp_valid_i && resp_ready_i[grant_q]`: go to Idle, and set `rr_q <= grant_q+1`, wrapping to 0 when `grant_q == NumReq-1`.

General rules:
- Every op (read, write, nop) is forwarded unchanged and yields exactly one response. Writes wait for their response like reads.
- The `op` encoding is not checked. A nop is passed through.
- Outside Resp: `dmi_resp_ready_o = 0`. Any `dmi_resp_valid_i` seen in Idle or Req is ignored and not consumed. The downstream must not produce unsolicited responses.
- Requests on non-granted indices wait. Their `req_valid_i` may be held or dropped; no state is kept for them.
- `NumReq == 1`: `rr_q` stays 0. Behaviour is otherwise identical.

## Timing
- Reset (asynchronous, `rst_ni = 0`): state = Idle, `rr_q = 0`, `grant_q = 0`, `req_q = 0`.
  - All outputs are 0: `req_ready_o`, `resp_valid_o`, `resp_o`, `dmi_req_o`, `dmi_req_valid_o`, `dmi_resp_ready_o`.
  - A transaction in flight is dropped silently.
- Request acceptance: `req_ready_o[i]` is combinational from `req_valid_i` in Idle. It is high for exactly one cycle per accepted request.
- Latency from accept to downstream: accept in cycle N gives `dmi_req_valid_o = 1` from N+1.
- `dmi_req_valid_o` stays high with `dmi_req_o` stable until `dmi_req_ready_i`. It must never drop without that handshake.
- The response path is combinational pass-through from downstream to the granted requester, with zero added latency.
- Minimum transaction period is 3 cycles: accept (Idle), request handshake (Req), response handshake (Resp). The next accept can occur in the cycle after the response handshake.
- Back-pressure: if `resp_ready_i[grant_q] = 0`, the block stays in Resp with `dmi_resp_ready_o = 0`.

## Test plan
1. **Single read.** Requester 0 sends addr 0x11, op read. Downstream is ready at once and returns data 0xDEADBEEF, resp 0 two cycles later.
   - `dmi_req_o.addr = 0x11` in cycle N+1.
   - `resp_valid_o = 2'b01` with data 0xDEADBEEF.
   - `rr_q = 1` afterwards.
2. **Round-robin fairness.** Both requesters hold valid continuously for 6 transactions, starting from reset.
   - Grant order is 0, 1, 0, 1, 0, 1.
   - `resp_valid_o` never targets the non-granted index.
3. **Downstream back-pressure.** `dmi_req_ready_i` is held at 0 for 5 cycles, then 1.
   - `dmi_req_valid_o` stays high and `dmi_req_o` stays unchanged all 5 cycles.
   - A second requester's `req_ready_o` stays 0 throughout.
4. **Response back-pressure.** Requester 1 write (addr 0x10, data 0x1). `resp_ready_i[1] = 0` for 3 cycles while `dmi_resp_valid_i = 1`.
   - `dmi_resp_ready_o = 0` for those 3 cycles.
   - Completion occurs on the cycle `resp_ready_i[1]` rises.
   - `rr_q` becomes 0.
5. **Reset mid-transaction.** Assert `rst_ni = 0` while in Resp.
   - All outputs go to 0 asynchronously.
   - After release, a new request from requester 1 is granted first only if requester 0 is idle, since `rr_q = 0`.
6. **NumReq = 3 wrap-around.** Requester 2 is granted last.
   - `rr_q` wraps to 0.
   - With requesters 0 and 2 both pending, requester 0 wins.

Source files
------------

// File: rtl/dmi_arbiter.sv
// dmi_arbiter: round-robin share of one DMI req/resp channel among NumReq requesters (req_i/req_valid_i/req_ready_o, resp_o/resp_valid_o/resp_ready_i upstream; dmi_req_*/dmi_resp_* downstream)
module dmi_arbiter #(
  parameter int NumReq = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NumReq-1:0][40:0] req_i,
  input  logic [NumReq-1:0]      req_valid_i,
  output logic [NumReq-1:0]      req_ready_o,
  output logic [33:0]            resp_o,
  output logic [NumReq-1:0]      resp_valid_o,
  input  logic [NumReq-1:0]      resp_ready_i,
  output logic [40:0]            dmi_req_o,
  output logic                   dmi_req_valid_o,
  input  logic                   dmi_req_ready_i,
  input  logic [33:0]            dmi_resp_i,
  input  logic                   dmi_resp_valid_i,
  output logic                   dmi_resp_ready_o
);
  localparam int W = NumReq > 1 ? $clog2(NumReq) : 1;
  localparam int P = 2 ** W;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  state_e st_q;
  logic [W-1:0] grant_q, rr_q, sel, cand;
  logic [W:0] sum;
  logic [40:0] req_q, req_sel;
  logic [P-1:0] valid_pad, rready_pad;
  logic hit, resp_done;
  assign valid_pad = P'(req_valid_i);
  assign rready_pad = P'(resp_ready_i);
  always_comb begin
    hit = 1'b0;
    sel = '0;
    sum = '0;
    cand = '0;
    for (int k = NumReq - 1; k >= 0; k--) begin
      sum = {1'b0, rr_q} + (W+1)'(k);
      cand = sum >= (W+1)'(NumReq) ? W'(sum - (W+1)'(NumReq)) : sum[W-1:0];
      if (valid_pad[cand]) begin
        hit = 1'b1;
        sel = cand;
      end
    end
  end
  always_comb begin
    req_sel = '0;
    req_ready_o = '0;
    resp_valid_o = '0;
    for (int i = 0; i < NumReq; i++) begin
      req_sel = sel == W'(i) ? req_i[i] : req_sel;
      req_ready_o[i] = rst_ni && st_q == IDLE && hit && sel == W'(i);
      resp_valid_o[i] = st_q == RESP && grant_q == W'(i) && dmi_resp_valid_i;
    end
  end
  assign dmi_req_valid_o = st_q == REQ;
  assign dmi_req_o = dmi_req_valid_o ? req_q : '0;
  assign resp_o = st_q == RESP ? dmi_resp_i : '0;
  assign dmi_resp_ready_o = st_q == RESP && rready_pad[grant_q];
  assign resp_done = dmi_resp_valid_i && dmi_resp_ready_o;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      st_q <= IDLE;
      grant_q <= '0;
      rr_q <= '0;
      req_q <= '0;
    end else begin
      case (st_q)
        IDLE: if (hit) begin
          st_q <= REQ;
          req_q <= req_sel;
          grant_q <= sel;
        end
        REQ: if (dmi_req_ready_i) st_q <= RESP;
        RESP: if (resp_done) begin
          st_q <= IDLE;
          rr_q <= grant_q == W'(NumReq - 1) ? '0 : grant_q + W'(1);
        end
        default: st_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dmi_arbiter.sv
// tb_dmi_arbiter: scoreboard bench for dmi_arbiter with NumReq=2 and NumReq=3 instances sharing one downstream driver
module tb_dmi_arbiter;
  logic clk = 1'b0;
  logic rst_ni = 1'b1;
  always #5 clk = ~clk;
  int inst, n_cmp, n_bad;
  logic [40:0] pay [3];
  logic [2:0] req_valid, resp_ready;
  logic dmi_req_ready, dmi_resp_valid;
  logic [33:0] dmi_resp;
  logic [1:0][40:0] req2;
  logic [1:0] rv2, rdy2, rspv2, rr2;
  logic [33:0] resp2;
  logic [40:0] dreq2;
  logic dreqv2, drr2;
  logic [2:0][40:0] req3;
  logic [2:0] rv3, rdy3, rspv3, rr3;
  logic [33:0] resp3;
  logic [40:0] dreq3;
  logic dreqv3, drr3;
  logic [2:0] v_rdy, v_rspv;
  logic [33:0] v_resp;
  logic [40:0] v_dreq;
  logic v_dreqv, v_drr;
  logic [40:0] exp_req [$];
  logic [36:0] exp_resp [$];
  assign req2 = {pay[1], pay[0]};
  assign req3 = {pay[2], pay[1], pay[0]};
  assign rv2 = inst == 0 ? req_valid[1:0] : 2'b00;
  assign rr2 = inst == 0 ? resp_ready[1:0] : 2'b00;
  assign rv3 = inst == 1 ? req_valid : 3'b000;
  assign rr3 = inst == 1 ? resp_ready : 3'b000;
  assign v_rdy = inst == 1 ? rdy3 : {1'b0, rdy2};
  assign v_rspv = inst == 1 ? rspv3 : {1'b0, rspv2};
  assign v_resp = inst == 1 ? resp3 : resp2;
  assign v_dreq = inst == 1 ? dreq3 : dreq2;
  assign v_dreqv = inst == 1 ? dreqv3 : dreqv2;
  assign v_drr = inst == 1 ? drr3 : drr2;
  dmi_arbiter #(.NumReq(2)) u2 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req2), .req_valid_i(rv2), .req_ready_o(rdy2),
    .resp_o(resp2), .resp_valid_o(rspv2), .resp_ready_i(rr2), .dmi_req_o(dreq2),
    .dmi_req_valid_o(dreqv2), .dmi_req_ready_i(dmi_req_ready), .dmi_resp_i(dmi_resp),
    .dmi_resp_valid_i(dmi_resp_valid), .dmi_resp_ready_o(drr2));
  dmi_arbiter #(.NumReq(3)) u3 (
    .clk_i(clk), .rst_ni(rst_ni), .req_i(req3), .req_valid_i(rv3), .req_ready_o(rdy3),
    .resp_o(resp3), .resp_valid_o(rspv3), .resp_ready_i(rr3), .dmi_req_o(dreq3),
    .dmi_req_valid_o(dreqv3), .dmi_req_ready_i(dmi_req_ready), .dmi_resp_i(dmi_resp),
    .dmi_resp_valid_i(dmi_resp_valid), .dmi_resp_ready_o(drr3));
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (v_dreqv && dmi_req_ready) begin
      if (exp_req.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL dmi_req: got unexpected %h expected none", v_dreq);
      end else check("dmi_req", 64'(v_dreq), 64'(exp_req.pop_front()));
    end
    if (|(v_rspv & resp_ready)) begin
      if (exp_resp.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL resp: got unexpected %h expected none", {v_rspv, v_resp});
      end else check("resp", 64'({v_rspv, v_resp}), 64'(exp_resp.pop_front()));
    end
  end
  task automatic chk_zero(input string tag);
    check({tag, "_req_ready"}, 64'(v_rdy), 64'(0));
    check({tag, "_resp_valid"}, 64'(v_rspv), 64'(0));
    check({tag, "_resp"}, 64'(v_resp), 64'(0));
    check({tag, "_dmi_req"}, 64'(v_dreq), 64'(0));
    check({tag, "_dmi_req_valid"}, 64'(v_dreqv), 64'(0));
    check({tag, "_dmi_resp_ready"}, 64'(v_drr), 64'(0));
  endtask
  task automatic do_reset();
    rst_ni = 1'b0;
    req_valid = 3'b111;
    #1;
    chk_zero("rst");
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
  endtask
  task automatic run(input logic [2:0] valid, input int g, input int req_wait, input int resp_gap,
                     input int resp_wait, input logic [31:0] rdata);
    logic [2:0] oh;
    logic [40:0] exp;
    oh = 3'b001 << g;
    exp = pay[g];
    req_valid = valid;
    exp_req.push_back(exp);
    exp_resp.push_back({oh, rdata, 2'b00});
    @(negedge clk);
    check("accept", 64'(v_rdy), 64'(oh));
    @(posedge clk);
    #1;
    req_valid = valid & ~oh;
    pay[g] = ~exp;
    dmi_req_ready = 1'b0;
    repeat (req_wait) begin
      @(negedge clk);
      check("req_hold_valid", 64'(v_dreqv), 64'(1));
      check("req_hold_data", 64'(v_dreq), 64'(exp));
      check("req_hold_noaccept", 64'(v_rdy), 64'(0));
      @(posedge clk);
      #1;
    end
    dmi_req_ready = 1'b1;
    @(posedge clk);
    #1;
    dmi_req_ready = 1'b0;
    repeat (resp_gap) begin
      @(negedge clk);
      check("resp_gap_valid", 64'(v_rspv), 64'(0));
      @(posedge clk);
      #1;
    end
    dmi_resp = {rdata, 2'b00};
    dmi_resp_valid = 1'b1;
    resp_ready = ~oh;
    repeat (resp_wait) begin
      @(negedge clk);
      check("resp_bp_ready", 64'(v_drr), 64'(0));
      check("resp_bp_valid", 64'(v_rspv), 64'(oh));
      @(posedge clk);
      #1;
    end
    resp_ready = 3'b111;
    @(negedge clk);
    check("resp_done_ready", 64'(v_drr), 64'(1));
    @(posedge clk);
    #1;
    dmi_resp_valid = 1'b0;
    resp_ready = 3'b000;
    req_valid = 3'b000;
    pay[g] = exp;
  endtask
  initial begin
    inst = 0;
    req_valid = '0;
    resp_ready = '0;
    dmi_req_ready = 1'b0;
    dmi_resp_valid = 1'b0;
    dmi_resp = '0;
    pay[0] = {7'h11, 2'b01, 32'h0};
    pay[1] = {7'h21, 2'b10, 32'hCAFE0001};
    pay[2] = {7'h22, 2'b00, 32'h0};
    do_reset();
    run(3'b001, 0, 0, 2, 0, 32'hDEADBEEF);
    run(3'b011, 1, 0, 0, 0, 32'h00000101);
    do_reset();
    pay[0] = {7'h20, 2'b01, 32'h0};
    for (int i = 0; i < 6; i++) run(3'b011, i % 2, 0, 0, 0, 32'hF0000000 + 32'(i));
    run(3'b011, 0, 5, 0, 0, 32'h00000303);
    pay[1] = {7'h10, 2'b10, 32'h1};
    run(3'b010, 1, 0, 0, 3, 32'h0);
    run(3'b011, 0, 0, 0, 0, 32'h00000404);
    pay[1] = {7'h33, 2'b01, 32'h0};
    req_valid = 3'b010;
    exp_req.push_back(pay[1]);
    @(negedge clk);
    check("mid_accept", 64'(v_rdy), 64'(3'b010));
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    dmi_req_ready = 1'b1;
    @(posedge clk);
    #1;
    dmi_req_ready = 1'b0;
    dmi_resp = {32'h5555AAAA, 2'b00};
    dmi_resp_valid = 1'b1;
    @(negedge clk);
    check("mid_in_resp", 64'(v_rspv), 64'(3'b010));
    check("mid_resp_data", 64'(v_resp), 64'({32'h5555AAAA, 2'b00}));
    #2;
    rst_ni = 1'b0;
    #1;
    chk_zero("mid_rst");
    dmi_resp_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    @(posedge clk);
    #1;
    run(3'b011, 0, 0, 0, 0, 32'h00000505);
    run(3'b010, 1, 0, 0, 0, 32'h00000606);
    inst = 1;
    do_reset();
    run(3'b100, 2, 0, 0, 0, 32'h00000707);
    run(3'b101, 0, 0, 0, 0, 32'h00000808);
    run(3'b110, 1, 0, 0, 0, 32'h00000909);
    run(3'b011, 0, 0, 0, 0, 32'h00000A0A);
    run(3'b111, 1, 0, 1, 1, 32'h00000B0B);
    check("req_queue_drained", 64'(exp_req.size()), 64'(0));
    check("resp_queue_drained", 64'(exp_resp.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
